valid_ready_buffered_responder: RTL
===================================

// Module: valid_ready_buffered_responder
// PURPOSE
//  Completer end of the single-requester/single-completer valid/ready link, with buffering and a return path.
//  Accepts requests (req_valid/req_ready/req_data) into a DEPTH-entry FIFO.
//  Returns each request to the requester as a response (rsp_valid/rsp_ready/rsp_data/rsp_seq), in order, tagged with a sequence number.
//  req_ready is driven by buffer status, not tied high, so the requester sees real back-pressure.
// PARAMETERS
//  DSIZE  8  request/response data width
//  DEPTH  4  FIFO entries; power of 2, >= 2
//  SEQW   4  sequence tag width; tag wraps modulo 2**SEQW
// PORTS
//  clk        in   1                  single clock, all logic on posedge
//  rst        in   1                  asynchronous, active-high reset
//  req_valid  in   1                  requester has data on req_data
//  req_data   in   DSIZE              request payload
//  req_ready  out  1                  responder can accept this cycle
//  rsp_valid  out  1                  response available on rsp_data/rsp_seq
//  rsp_data   out  DSIZE              response payload (= accepted req_data)
//  rsp_seq    out  SEQW               tag assigned at acceptance
//  rsp_ready  in   1                  requester consumes response this cycle
//  occupancy  out  $clog2(DEPTH)+1    entries currently held
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Handshake events:
//   - push = req_valid & req_ready
//   - pop  = rsp_valid & rsp_ready
//  Reset (rst=1, async):
//   - req_ready=0, rsp_valid=0, rsp_data=0, rsp_seq=0, occupancy=0.
//   - Write/read pointers and the sequence counter clear to 0.
//   - FIFO storage is not reset.
//  After rst falls, the first posedge sets an internal enable flop; req_ready=1 from that cycle on (buffer empty).
//  req_ready = enable & (occupancy != DEPTH), all from registered state.
//   - No combinational path rsp_ready -> req_ready.
//   - When full, a same-cycle pop does NOT allow a push; req_ready rises the cycle after the pop.
//  rsp_valid = (occupancy != 0), registered state only.
//   - rsp_data/rsp_seq = head entry (first-word fall-through).
//   - rsp_data/rsp_seq are forced to 0 when rsp_valid=0.
//  Latency: push at edge N into an empty buffer gives rsp_valid=1 with that data in the cycle after edge N (1 cycle).
//  Ordering: strict FIFO; responses leave in acceptance order.
//  Sequence tag:
//   - On push, the entry stores {seq_cnt, req_data}, then seq_cnt increments.
//   - Wraps 2**SEQW-1 -> 0; increments only on push.
//  Stall: while rsp_valid=1 and rsp_ready=0, rsp_data/rsp_seq/rsp_valid hold stable.
//  Occupancy and pointers:
//   - push only: +1
//   - pop only: -1
//   - push & pop: unchanged, both pointers advance
//   - neither: hold
//   - Pointers wrap DEPTH-1 -> 0.
//  Empty boundary: a push and an idle-to-valid response can never pop the same entry in the same cycle; the pushed word appears next cycle.
//  Throughput: back-to-back push every cycle while not full; with rsp_ready=1 continuously, one response per cycle at steady state.
//  req_valid while req_ready=0: ignored, no state change; the requester holds data by protocol.
//  rst asserted mid-operation: all buffered entries are discarded immediately, outputs take reset values, and seq restarts at 0.
// TESTING
//  1. Reset then idle: rst 1->0, no req_valid -> req_ready=0 during rst and 1 one cycle later; rsp_valid=0; occupancy=0.
//  2. Single transfer: push 0xA5 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0xA5, rsp_seq=0; then occupancy=0.
//  3. Fill/back-pressure:
//     - Stimulus: rsp_ready=0, push 0x01..0x04 on consecutive cycles.
//     - Occupancy: 4, with req_ready=0 after the 4th push.
//     - Extra req_valid with 0x05 is not accepted.
//     - Then rsp_ready=1: responses come out 0x01..0x04 with seq 0..3.
//  4. Full with simultaneous pop: at occupancy=4, rsp_ready=1 and req_valid=1 -> no push that cycle; push accepted next cycle; occupancy 4->3->4.
//  5. Streaming/wrap: 20 back-to-back pushes with rsp_ready=1 -> 20 in-order responses; rsp_seq 0..15,0..3; no bubbles after the first response.
//  6. Mid-operation reset: occupancy=3, assert rst for 1 cycle -> rsp_valid=0 immediately; after release, the next push returns rsp_seq=0.
//  Assertions:
//   - rsp_data/rsp_seq stable while stalled.
//   - occupancy <= DEPTH.
//   - No push while occupancy==DEPTH.

Source files
------------

// File: rtl/valid_ready_buffered_responder.sv
// Purpose     : completer end of a single-requester valid/ready link; requests are buffered in a
//               DEPTH-entry FIFO and returned in order as responses tagged with a sequence number.
// Latency     : 1 cycle from request acceptance to rsp_valid with that word (first-word fall-through).
// Backpressure: req_ready drops while full, from registered state only; a pop in a full cycle frees
//               a slot that the requester can use on the following cycle.
//
// Ports:
//   clk, rst                 single clock; asynchronous active-high reset
//   req_valid/req_ready      request handshake, payload on req_data
//   rsp_valid/rsp_ready      response handshake, payload on rsp_data, tag on rsp_seq
//   occupancy                number of entries currently buffered
module valid_ready_buffered_responder #(
    parameter int DSIZE = 8,
    parameter int DEPTH = 4,
    parameter int SEQW  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [DSIZE-1:0]         req_data,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [DSIZE-1:0]         rsp_data,
    output logic [SEQW-1:0]          rsp_seq,
    input  logic                     rsp_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [SEQW-1:0]  seq;
        logic [DSIZE-1:0] dat;
    } entry_t;

    // Storage carries no reset; entries are only ever read when occupancy says they are valid.
    entry_t          mem [DEPTH];

    logic            en;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     occ;
    logic [SEQW-1:0] seq_cnt;
    logic            push;
    logic            pop;
    entry_t          head;

    // Both handshake qualifiers come purely from flops, so rsp_ready never reaches req_ready
    // combinationally; a full buffer stays closed for the cycle in which it is being drained.
    assign req_ready = en & (occ != OCC_FULL);
    assign rsp_valid = (occ != '0);

    assign push = req_valid & req_ready;
    assign pop  = rsp_valid & rsp_ready;

    // Head entry is presented directly; zeroed while nothing is buffered so stale
    // storage never leaks onto the response bus.
    assign head      = mem[rd_ptr];
    assign rsp_data  = rsp_valid ? head.dat : '0;
    assign rsp_seq   = rsp_valid ? head.seq : '0;
    assign occupancy = occ;

    // Enable opens the request side one cycle after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en <= 1'b0;
        end else begin
            en <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{seq: seq_cnt, dat: req_data};
        end
    end

    // Pointers are AW bits wide, so they wrap DEPTH-1 -> 0 naturally (DEPTH is a power of 2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            seq_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                seq_cnt <= seq_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule
